// File: rtl/beam_emitter.sv
// IR break-beam emitter: gated carrier bursts separated by dark gaps, with the
// receiver level latched at the end of each burst to report beam state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | emitter dark, waiting for en
// S_BURST | carrier on: CARRIER_DIV clks high, CARRIER_DIV clks low, x BURST_CYCLES
// S_GAP   | emitter dark for GAP_CYCLES carrier periods, en checked every clk
module beam_emitter #(
    parameter int CARRIER_DIV   = 1316,
    parameter int BURST_CYCLES  = 16,
    parameter int GAP_CYCLES    = 16,
    parameter bit RX_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rx_clean,
    output logic        ir_out,
    output logic        burst_start,
    output logic        beam_broken,
    output logic        beam_valid,
    output logic [15:0] burst_count
);

    localparam int HALF_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int PER_MAX = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
    localparam int PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

    localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(CARRIER_DIV - 1);
    localparam logic [PER_W-1:0]  BURST_LOAD = PER_W'(BURST_CYCLES - 1);
    localparam logic [PER_W-1:0]  GAP_LOAD   = PER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic                hi_half_q, hi_half_d;
    logic [PER_W-1:0]    period_cnt_q, period_cnt_d;
    logic                ir_out_d, burst_start_d, beam_broken_d, beam_valid_d;
    logic [15:0]         burst_count_d;

    logic half_done, period_done, seg_done, rx_broken;
    logic start_burst, go_idle;

    // Both BURST and GAP time themselves with the same half-period / period
    // down-counters; a segment ends on the terminal count of the low half.
    assign half_done   = (half_cnt_q == '0);
    assign period_done = half_done && !hi_half_q;
    assign seg_done    = period_done && (period_cnt_q == '0);
    assign rx_broken   = RX_ACTIVE_LOW ? rx_clean : ~rx_clean;

    always_comb begin
        state_d       = state_q;
        half_cnt_d    = half_cnt_q;
        hi_half_d     = hi_half_q;
        period_cnt_d  = period_cnt_q;
        ir_out_d      = 1'b0;
        burst_start_d = 1'b0;
        beam_valid_d  = 1'b0;
        beam_broken_d = beam_broken;
        burst_count_d = burst_count;
        start_burst   = 1'b0;
        go_idle       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) start_burst = 1'b1;
            end
            S_BURST: begin
                if (seg_done) begin
                    beam_valid_d  = 1'b1;
                    beam_broken_d = rx_broken;
                    burst_count_d = burst_count + 16'd1;
                    if (!en) begin
                        go_idle = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        start_burst = 1'b1;
                    end else begin
                        state_d      = S_GAP;
                        half_cnt_d   = HALF_LOAD;
                        hi_half_d    = 1'b1;
                        period_cnt_d = GAP_LOAD;
                    end
                end else begin
                    if (half_done) begin
                        half_cnt_d = HALF_LOAD;
                        hi_half_d  = ~hi_half_q;
                        if (!hi_half_q) period_cnt_d = period_cnt_q - PER_W'(1);
                    end else begin
                        half_cnt_d = half_cnt_q - HALF_W'(1);
                    end
                    ir_out_d = hi_half_d;
                end
            end
            S_GAP: begin
                if (!en) begin
                    go_idle = 1'b1;
                end else if (seg_done) begin
                    start_burst = 1'b1;
                end else if (half_done) begin
                    half_cnt_d = HALF_LOAD;
                    hi_half_d  = ~hi_half_q;
                    if (!hi_half_q) period_cnt_d = period_cnt_q - PER_W'(1);
                end else begin
                    half_cnt_d = half_cnt_q - HALF_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (start_burst) begin
            state_d       = S_BURST;
            half_cnt_d    = HALF_LOAD;
            hi_half_d     = 1'b1;
            period_cnt_d  = BURST_LOAD;
            ir_out_d      = 1'b1;
            burst_start_d = 1'b1;
        end
        if (go_idle) begin
            state_d      = S_IDLE;
            half_cnt_d   = '0;
            hi_half_d    = 1'b0;
            period_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            half_cnt_q   <= '0;
            hi_half_q    <= 1'b0;
            period_cnt_q <= '0;
            ir_out       <= 1'b0;
            burst_start  <= 1'b0;
            beam_broken  <= 1'b0;
            beam_valid   <= 1'b0;
            burst_count  <= '0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            hi_half_q    <= hi_half_d;
            period_cnt_q <= period_cnt_d;
            ir_out       <= ir_out_d;
            burst_start  <= burst_start_d;
            beam_broken  <= beam_broken_d;
            beam_valid   <= beam_valid_d;
            burst_count  <= burst_count_d;
        end
    end

endmodule
